// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard sequencer for the 5-stage MIPS core, placed beside the
// control unit in ID.  Every cycle it looks at the ID, EX and MEM stage fields
// and drives the bubble request, the PC / IF-ID load enables, the stage
// flushes and the PC-source selects.
//
// Hazards handled, highest priority first:
//   - data-memory wait   : freezes the whole pipeline, nothing else moves
//   - taken branch (MEM) : redirect PC, flush IF/ID, ID/EX and EX/MEM
//   - load-use (ID vs EX): LOAD_USE_BUBBLES bubble cycles
//   - jump (ID)          : redirect PC, flush IF/ID
//
// Parameters:
//   LOAD_USE_BUBBLES  bubbles per load-use hazard, legal range 1..3
//
// Optional feature (compile-time macro):
//   HAZARD_PERF_CNT_EN  builds the saturating stall / flush performance
//                       counters; when undefined both counter outputs are 0.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   idOpcode, idRs, idRt, idJump    ID-stage instruction fields / Jump control
//   exMemRead, exRt                 ID/EX MemRead and load destination
//   memBranch, memFlagBranch,
//   memZero                         EX/MEM branch info (flagBranch 1=BEQ 0=BNE)
//   memReq, memReady                data-memory request / completion
//   outStall                        to control unit inStall (1 normal, 0 bubble)
//   pcWrite, ifIdWrite              PC and IF/ID load enables
//   pipeHold                        freezes ID/EX, EX/MEM, MEM/WB
//   ifIdFlush, idExFlush, exMemFlush synchronous stage clears
//   pcSrcBranch, pcSrcJump          PC mux selects
//   stallCount, flushCount          performance counters
//
// All control outputs are combinational from state and inputs; while rst_n
// is low they are forced to their reset values (including the enables).
// ---------------------------------------------------------------------------
module hazard_controller #(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  idOpcode,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idJump,
  input  logic        exMemRead,
  input  logic [4:0]  exRt,
  input  logic        memBranch,
  input  logic        memFlagBranch,
  input  logic        memZero,
  input  logic        memReq,
  input  logic        memReady,
  output logic        outStall,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        pipeHold,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        exMemFlush,
  output logic        pcSrcBranch,
  output logic        pcSrcJump,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  // Bubbles still owed after the detection cycle itself.
  localparam logic [1:0] LU_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] lu_cnt_r;
  logic [1:0] lu_cnt_nxt_s;

  logic load_use_s;
  logic br_taken_s;
  logic mem_wait_s;

  // Ungated (post-reset) values of the control outputs.
  logic out_stall_s;
  logic pc_write_s;
  logic if_id_write_s;
  logic pipe_hold_s;
  logic if_id_flush_s;
  logic id_ex_flush_s;
  logic ex_mem_flush_s;
  logic pc_src_branch_s;
  logic pc_src_jump_s;

  // J (2) and JAL (3) carry a target instead of an rs field.
  function automatic logic uses_rs(input logic [5:0] op);
    return (op != 6'd2) && (op != 6'd3);
  endfunction

  // R-type, BEQ, BNE and the stores read rt as a source.
  function automatic logic uses_rt(input logic [5:0] op);
    logic r;
    case (op)
      6'd0, 6'd4, 6'd5, 6'd40, 6'd41, 6'd43: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

  // Hazard detection terms.
  always_comb begin
    load_use_s = exMemRead && (exRt != 5'd0) &&
                 ((uses_rs(idOpcode) && (idRs == exRt)) ||
                  (uses_rt(idOpcode) && (idRt == exRt)));
    br_taken_s = memBranch && (memZero == memFlagBranch);
    mem_wait_s = memReq && !memReady;
  end

  // Prioritised next-state and control decode.
  always_comb begin
    state_nxt_s     = state_r;
    lu_cnt_nxt_s    = lu_cnt_r;
    out_stall_s     = 1'b1;
    pc_write_s      = 1'b1;
    if_id_write_s   = 1'b1;
    pipe_hold_s     = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_flush_s  = 1'b0;
    pc_src_branch_s = 1'b0;
    pc_src_jump_s   = 1'b0;

    if (mem_wait_s) begin
      // Whole pipeline frozen; a taken branch waits to be seen again.
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      pipe_hold_s   = 1'b1;
    end else if (br_taken_s) begin
      // Wrong-path instructions in IF/ID/EX die; pending bubbles are moot.
      pc_src_branch_s = 1'b1;
      if_id_flush_s   = 1'b1;
      id_ex_flush_s   = 1'b1;
      ex_mem_flush_s  = 1'b1;
      state_nxt_s     = RUN;
      lu_cnt_nxt_s    = 2'd0;
    end else if ((state_r == RUN) && load_use_s) begin
      out_stall_s   = 1'b0;
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      if (LOAD_USE_BUBBLES > 1) begin
        state_nxt_s  = LU_STALL;
        lu_cnt_nxt_s = LU_RELOAD;
      end else begin
        state_nxt_s  = RUN;
        lu_cnt_nxt_s = 2'd0;
      end
    end else if (state_r == LU_STALL) begin
      out_stall_s   = 1'b0;
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      // A count of 0 here is never expected; treat it as the last bubble.
      if (lu_cnt_r <= 2'd1) begin
        state_nxt_s  = RUN;
        lu_cnt_nxt_s = 2'd0;
      end else begin
        state_nxt_s  = LU_STALL;
        lu_cnt_nxt_s = lu_cnt_r - 2'd1;
      end
    end else if (idJump) begin
      pc_src_jump_s = 1'b1;
      if_id_flush_s = 1'b1;
    end else begin
      state_nxt_s  = RUN;
      lu_cnt_nxt_s = lu_cnt_r;
    end
  end

  // FSM state and bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      lu_cnt_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      lu_cnt_r <= lu_cnt_nxt_s;
    end
  end

  // Output gating: during reset even the load enables are held low.
  always_comb begin
    if (!rst_n) begin
      outStall    = 1'b0;
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      pipeHold    = 1'b0;
      ifIdFlush   = 1'b0;
      idExFlush   = 1'b0;
      exMemFlush  = 1'b0;
      pcSrcBranch = 1'b0;
      pcSrcJump   = 1'b0;
    end else begin
      outStall    = out_stall_s;
      pcWrite     = pc_write_s;
      ifIdWrite   = if_id_write_s;
      pipeHold    = pipe_hold_s;
      ifIdFlush   = if_id_flush_s;
      idExFlush   = id_ex_flush_s;
      exMemFlush  = ex_mem_flush_s;
      pcSrcBranch = pc_src_branch_s;
      pcSrcJump   = pc_src_jump_s;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if ((!outStall || pipeHold) && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((ifIdFlush || idExFlush || exMemFlush) && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stallCount = stall_cnt_r;
  assign flushCount = flush_cnt_r;
`else
  assign stallCount = 16'd0;
  assign flushCount = 16'd0;
`endif

endmodule
